// File: rtl/serial_mag_comparator_if.sv
// Handshake and operand/result bundle for serial_mag_comparator.
// The master drives the request side, the slave (the comparator) drives the result side.
interface serial_mag_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             signed_i;
    logic             fe_i;
    logic             fl_i;
    logic             fg_i;
    logic             busy_o;
    logic             done_o;
    logic             fe_o;
    logic             fl_o;
    logic             fg_o;

    modport master (
        output start_i, a_i, b_i, signed_i, fe_i, fl_i, fg_i,
        input  busy_o, done_o, fe_o, fl_o, fg_o
    );

    modport slave (
        input  start_i, a_i, b_i, signed_i, fe_i, fl_i, fg_i,
        output busy_o, done_o, fe_o, fl_o, fg_o
    );
endinterface

// File: rtl/serial_mag_comparator.sv
// Digit-serial, MSB-first magnitude comparator with cascade inputs, signed/unsigned
// mode and optional early exit on the first differing digit.
module serial_mag_comparator #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_mag_comparator_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    typedef enum logic [1:0] {RES_EQ, RES_LT, RES_GT} res_t;

    state_t           state, state_next;
    res_t             res_q, cascade_res, digit_res, final_res;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic [CW-1:0]    cnt;
    logic             found;
    logic             accept, last_digit, stop_scan;
    logic             fe_q, fl_q, fg_q;

    function automatic logic [2:0] flags_of(input res_t r);
        case (r)
            RES_LT:  return 3'b010;
            RES_GT:  return 3'b001;
            default: return 3'b100;
        endcase
    endfunction

    assign accept     = bus.start_i && (state == IDLE || state == DONE);
    assign a_dig      = a_sh[WIDTH-1 -: DIGIT];
    assign b_dig      = b_sh[WIDTH-1 -: DIGIT];
    assign last_digit = (cnt == CW'(NDIG - 1));
    assign stop_scan  = last_digit || (EARLY_EXIT != 0 && !found && digit_res != RES_EQ);
    assign final_res  = found ? res_q : digit_res;

    // fl_i outranks fg_i; with neither set the more-significant part counts as equal.
    always_comb begin
        cascade_res = RES_EQ;
        if (bus.fl_i)      cascade_res = RES_LT;
        else if (bus.fg_i) cascade_res = RES_GT;
    end

    always_comb begin
        digit_res = RES_EQ;
        if (a_dig < b_dig)      digit_res = RES_LT;
        else if (a_dig > b_dig) digit_res = RES_GT;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: a default assignment first keeps this combinational block from inferring latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_next = (cascade_res == RES_EQ) ? SCAN : DONE;
                else        state_next = IDLE;
            end
            SCAN:    if (stop_scan) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o = (state == SCAN);
        bus.done_o = (state == DONE);
        bus.fe_o   = fe_q;
        bus.fl_o   = fl_q;
        bus.fg_o   = fg_q;
    end

    // Inverting both MSBs at capture turns a two's-complement compare into an unsigned one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            found <= 1'b0;
            res_q <= RES_EQ;
            {fe_q, fl_q, fg_q} <= 3'b000;
        end else if (accept) begin
            a_sh  <= bus.signed_i ? (bus.a_i ^ MSB_MASK) : bus.a_i;
            b_sh  <= bus.signed_i ? (bus.b_i ^ MSB_MASK) : bus.b_i;
            cnt   <= '0;
            found <= 1'b0;
            res_q <= RES_EQ;
            if (cascade_res != RES_EQ) {fe_q, fl_q, fg_q} <= flags_of(cascade_res);
        end else if (state == SCAN) begin
            a_sh <= a_sh << DIGIT;
            b_sh <= b_sh << DIGIT;
            cnt  <= cnt + 1'b1;
            if (!found && digit_res != RES_EQ) begin
                found <= 1'b1;
                res_q <= digit_res;
            end
            if (stop_scan) {fe_q, fl_q, fg_q} <= flags_of(final_res);
        end
    end
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench: two comparators (early exit on / off) share stimulus; expected
// flags and done cycle are queued on start and checked when done_o appears.
module tb_serial_mag_comparator;
    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    typedef struct {
        int         due;
        int         lat;
        logic [2:0] flags;   // {fe, fl, fg}
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [WIDTH-1:0] a = '0, b = '0;
    logic             sgn = 1'b0, cfe = 1'b0, cfl = 1'b0, cfg = 1'b0;
    logic [1:0]       start = 2'b00;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    serial_mag_comparator_if #(.WIDTH(WIDTH)) bus0 ();
    serial_mag_comparator_if #(.WIDTH(WIDTH)) bus1 ();

    assign bus0.start_i = start[0];
    assign bus1.start_i = start[1];
    assign bus0.a_i = a;      assign bus1.a_i = a;
    assign bus0.b_i = b;      assign bus1.b_i = b;
    assign bus0.signed_i = sgn; assign bus1.signed_i = sgn;
    assign bus0.fe_i = cfe;   assign bus1.fe_i = cfe;
    assign bus0.fl_i = cfl;   assign bus1.fl_i = cfl;
    assign bus0.fg_i = cfg;   assign bus1.fg_i = cfg;

    serial_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    serial_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain integer compare for the result, first nonzero digit of a^b for latency.
    function automatic exp_t model(input bit early, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                   input logic s, input logic l, input logic g, input int k);
        exp_t             e;
        logic [WIDTH-1:0] x;
        logic             lt, gt;
        x = aa ^ bb;
        if (l) begin
            e.flags = 3'b010; e.lat = 1;
        end else if (g) begin
            e.flags = 3'b001; e.lat = 1;
        end else begin
            if (s) begin
                lt = $signed(aa) < $signed(bb);
                gt = $signed(aa) > $signed(bb);
            end else begin
                lt = aa < bb;
                gt = aa > bb;
            end
            e.flags = lt ? 3'b010 : (gt ? 3'b001 : 3'b100);
            e.lat = NDIG + 1;
            if (early)
                for (int i = NDIG - 1; i >= 0; i--)
                    if (x[WIDTH-1-DIGIT*i -: DIGIT] != '0) e.lat = i + 2;
        end
        e.due = k + e.lat - 1;
        return e;
    endfunction

    // Called at a falling edge; the start is taken on the next rising edge.
    task automatic drive_start(input int d, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                               input logic s, input logic f_e, input logic f_l, input logic f_g,
                               output int lat);
        exp_t e;
        a = aa; b = bb; sgn = s; cfe = f_e; cfl = f_l; cfg = f_g;
        start[d] = 1'b1;
        e = model(d == 0, aa, bb, s, f_l, f_g, cyc + 1);
        lat = e.lat;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_done(input int d, input int exp_busy, input string tag);
        int bc = 0;
        bit seen = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            if (d == 0 ? bus0.busy_o : bus1.busy_o) bc++;
            if (d == 0 ? bus0.done_o : bus1.done_o) seen = 1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, bc, exp_busy);
    endtask

    task automatic do_op(input int d, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                         input logic s, input logic f_e, input logic f_l, input logic f_g, input string tag);
        int lat;
        @(negedge clk);
        drive_start(d, aa, bb, s, f_e, f_l, f_g, lat);
        @(negedge clk);
        start[d] = 1'b0;
        wait_done(d, lat - 1, tag);
    endtask

    // Scoreboard side: every done_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus0.done_o) begin
            check("d0_pending", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                check("d0_latency", cyc, e0.due);
                check("d0_flags", {bus0.fe_o, bus0.fl_o, bus0.fg_o}, e0.flags);
            end
        end
        if (bus1.done_o) begin
            check("d1_pending", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check("d1_latency", cyc, e1.due);
                check("d1_flags", {bus1.fe_o, bus1.fl_o, bus1.fg_o}, e1.flags);
            end
        end
        if (bus0.busy_o || bus0.done_o) check("d0_busy_done_overlap", 32'(bus0.busy_o & bus0.done_o), 32'd0);
        if (bus1.busy_o || bus1.done_o) check("d1_busy_done_overlap", 32'(bus1.busy_o & bus1.done_o), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, lat2, ndone;
        logic [WIDTH-1:0] ra, rb;
        repeat (3) @(negedge clk);
        check("rst_d0_outputs", {bus0.busy_o, bus0.done_o, bus0.fe_o, bus0.fl_o, bus0.fg_o}, 32'd0);
        check("rst_d1_outputs", {bus1.busy_o, bus1.done_o, bus1.fe_o, bus1.fl_o, bus1.fg_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op(0, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, "eq_full");
        do_op(0, 16'h9000, 16'h1FFF, 1'b0, 1'b0, 1'b0, 1'b0, "early_uns");
        do_op(0, 16'h9000, 16'h1FFF, 1'b1, 1'b0, 1'b0, 1'b0, "early_sgn");
        do_op(1, 16'h00F1, 16'h00F2, 1'b0, 1'b1, 1'b0, 1'b0, "const_lat_lt");
        do_op(1, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, "const_lat_sgn");
        do_op(1, 16'h9000, 16'h1FFF, 1'b0, 1'b1, 1'b0, 1'b0, "const_lat_gt");
        do_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, "casc_lt");
        do_op(0, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, "casc_gt");
        do_op(1, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, "casc_prio");
        do_op(0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "casc_zero_d0");
        do_op(1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "casc_zero_d1");
        do_op(0, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, "sgn_gt");

        // start_i during SCAN is dropped; only the first result may appear
        @(negedge clk);
        drive_start(1, 16'h1234, 16'h1235, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        @(negedge clk); start[1] = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; start[1] = 1'b1;
        @(negedge clk); start[1] = 1'b0;
        wait_done(1, lat - 3, "ignore_mid_scan");
        repeat (8) @(negedge clk);

        // back-to-back: second start lands in the DONE cycle of the first
        drive_start(0, 16'h5000, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        @(negedge clk); start[0] = 1'b0;
        @(negedge clk);
        check("b2b_first_done", 32'(bus0.done_o), 32'd1);
        drive_start(0, 16'h0002, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, lat2);
        @(negedge clk); start[0] = 1'b0;
        wait_done(0, lat2 - 1, "b2b_second");

        // asynchronous reset in the middle of a scan aborts it silently
        @(negedge clk);
        drive_start(1, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        @(negedge clk); start[1] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_d1_outputs", {bus1.busy_o, bus1.done_o, bus1.fe_o, bus1.fl_o, bus1.fg_o}, 32'd0);
        check("abort_d0_outputs", {bus0.busy_o, bus0.done_o, bus0.fe_o, bus0.fl_o, bus0.fg_o}, 32'd0);
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus1.done_o || bus0.done_o) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_op(1, 16'hA5A5, 16'hA5A4, 1'b0, 1'b1, 1'b0, 1'b0, "after_abort");

        // random operands, often differing in a single digit so early exit varies
        for (int i = 0; i < 16; i++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? (ra ^ (WIDTH'($urandom) & (WIDTH'(16'hF) << (DIGIT * $urandom_range(0, NDIG - 1)))))
                                            : WIDTH'($urandom);
            do_op(i % 2, ra, rb, 1'($urandom_range(0, 1)), 1'b1,
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), "random");
        end

        repeat (4) @(negedge clk);
        check("d0_queue_drained", q0.size(), 0);
        check("d1_queue_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
